stream_frame_buffer: RTL and testbench
======================================

# stream_frame_buffer

Elastic single-frame buffer that sits on the output side of a conv layer: it receives the layer's `y` stream (valid/ready), stores one complete frame of DEPTH words, then replays it in order as an `x`-style valid/ready stream into the next layer. Fill and drain phases alternate and never overlap, which lets conv layers be chained without the producer having to stall mid-frame on the consumer's upload phase.

## Interface
- WIDTH, 8, word width in bits (signed, passed through unmodified)
- DEPTH, 13, words per frame (X−F+1 for a 16/4 conv); DEPTH ≥ 2
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- in_data  input  WIDTH  incoming word (the upstream layer's y_data)
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  WIDTH  outgoing word (the downstream layer's x_data)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts this cycle
- frame_done  output  1  one-cycle pulse in the cycle after the last word of a frame is accepted downstream

## Operation
- States: FILL, PRIME, DRAIN.
- FILL: in_ready=1, out_valid=0. On in_valid&in_ready, write in_data to mem[wr_cnt], wr_cnt++. The handshake on wr_cnt==DEPTH−1 sets wr_cnt=0 and moves to PRIME.
- PRIME (exactly 1 cycle): in_ready=0, out_valid=0. Issue a read of address 0 and set rd_cnt=0. Move to DRAIN.
- DRAIN: in_ready=0, out_valid=1, out_data = registered RAM output. The RAM read address is combinational lookahead: rd_cnt+1 on an out handshake, otherwise rd_cnt. As a result out_data stays stable under stall and advances with no bubble. On a handshake with rd_cnt==DEPTH−1: rd_cnt=0, go to FILL, and assert frame_done next cycle.
- RAM address mux: wr_cnt in FILL, read address otherwise. Single port only; reads and writes are never concurrent.
- in_valid outside FILL is ignored. No data is lost, because in_ready=0.
- out_ready with out_valid=0 has no effect.
- No arithmetic. Words are stored and replayed bit-exact, in arrival order.

## Timing
- Reset values: state=FILL, wr_cnt=0, rd_cnt=0, frame_done=0, out_valid=0. in_ready=0 while reset is high; it is 1 in the first cycle after reset deasserts.
- Reset mid-frame, in any state: the partial frame is discarded. Afterwards the block behaves exactly as from power-up. Stale RAM contents are never emitted, because DRAIN is only reached via a full FILL.
- Fill throughput: 1 word/cycle.
- Drain throughput: 1 word/cycle with out_ready held high.
- Latency: last input accepted at edge t → PRIME during cycle t+1 → out_valid=1 with word 0 during cycle t+2.
- Frame turnaround: last output accepted at edge u → FILL with in_ready=1 and frame_done=1 during cycle u+1.
- Backpressure: out_valid, once asserted, stays high until the frame completes. out_data changes only after a handshake.
- Counters never wrap past DEPTH−1. Both reset to 0 on each phase change.

## Structure
- Shared package: state enum typedef (FILL/PRIME/DRAIN), and a counter-width constant function $clog2(DEPTH).
- One sub-module: the team's synchronous-read single-port `memory` #(WIDTH, DEPTH), with a 1-cycle read latency and write enable = FILL handshake.
- FSM, counters and the address mux live in the top module.

## Test plan
- Basic frame: push 0..12 with in_valid held high, out_ready held high → in_ready drops after word 12; out_valid rises 2 cycles later; out_data reads 0..12 on 13 consecutive cycles; frame_done pulses once.
- Signed passthrough: push −128, 127, −1, then 10 zeros → outputs are −128, 127, −1, 0… bit-exact.
- Random stalls: in_valid and out_ready each toggled at 50% random → output sequence equals input sequence; out_data is stable during every out_valid&~out_ready cycle.
- Back-to-back frames: frame A = 1..13, frame B = 101..113, with B offered during A's drain → B is not accepted until frame_done; output is A then B in order.
- Reset mid-fill after 5 words, then a full frame of 50..62 → output is exactly 50..62, with no leftover words.
- Reset mid-drain after 3 outputs → out_valid=0 the next cycle and in_ready=1 after reset deasserts; the following frame replays correctly.

Source files
------------

// File: rtl/stream_frame_buffer_pkg.sv
// Shared types and helpers for the stream frame buffer.
//   state_e   : fill / prime / drain phase encoding
//   cnt_width : bit width of a counter that indexes DEPTH words
package stream_frame_buffer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A counter must be at least one bit wide, even for a tiny depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    if (depth > 1) w = unsigned'($clog2(depth));
    return w;
  endfunction

endpackage

// File: rtl/stream_frame_buffer_if.sv
// Handshake bundle for the stream frame buffer.
//   in_data/in_valid/in_ready     : upstream y stream into the buffer
//   out_data/out_valid/out_ready  : downstream x stream out of the buffer
//   frame_done                    : one-cycle pulse after the final output word
//   master : upstream/downstream side (testbench or neighbouring layers)
//   slave  : the buffer itself
interface stream_frame_buffer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, frame_done
  );
endinterface

// File: rtl/stream_frame_buffer_memory.sv
// Single-port RAM with a registered, one-cycle-latency read.
//   clk     : clock
//   we_i    : write enable; a write cycle leaves rdata_o unchanged
//   addr_i  : word address, shared by reads and writes
//   wdata_i : write data
//   rdata_o : data read from addr_i on the previous edge
module stream_frame_buffer_memory
  import stream_frame_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 13,
  parameter int unsigned AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // One port: either write this cycle or read this cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    else      rdata_q       <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_frame_buffer.sv
// Elastic single-frame buffer: captures DEPTH words from the upstream stream,
// then replays them in order downstream. Fill and drain never overlap.
//   clk   : clock
//   reset : synchronous, active-high; discards any partial frame
//   bus   : slave side of stream_frame_buffer_if (in_*, out_*, frame_done)
module stream_frame_buffer
  import stream_frame_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  stream_frame_buffer_if.slave  bus
);

  localparam int unsigned   CW   = cnt_width(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    rd_addr_c;
  logic [CW-1:0]    addr_c;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             in_ready_c;
  logic             in_hs_c;
  logic             out_hs_c;
  logic             we_c;
  logic [WIDTH-1:0] rdata_c;

  // in_ready is held low for as long as reset is asserted.
  assign in_ready_c = (state_q == FILL) && !reset;
  assign in_hs_c    = bus.in_valid && in_ready_c;
  assign out_hs_c   = out_valid_q && bus.out_ready;

  // Next state, counters and the RAM read-address lookahead.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_addr_c    = rd_cnt_q;
    we_c         = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      FILL: begin
        if (in_hs_c) begin
          we_c = 1'b1;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = PRIME;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      PRIME: begin
        rd_addr_c = '0;
        rd_cnt_d  = '0;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (out_hs_c) begin
          if (rd_cnt_q == LAST) begin
            // Hold the address so the lookahead never runs past the frame.
            rd_cnt_d     = '0;
            state_d      = FILL;
            frame_done_d = 1'b1;
          end else begin
            // Fetch the next word now so it is ready with no bubble.
            rd_cnt_d  = rd_cnt_q + CW'(1);
            rd_addr_c = rd_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase

    addr_c      = (state_q == FILL) ? wr_cnt_q : rd_addr_c;
    out_valid_d = (state_d == DRAIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  stream_frame_buffer_memory #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (CW)
  ) u_memory (
    .clk     (clk),
    .we_i    (we_c),
    .addr_i  (addr_c),
    .wdata_i (bus.in_data),
    .rdata_o (rdata_c)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.out_data   = rdata_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_stream_frame_buffer.sv
// Directed bench for stream_frame_buffer: whole frames with fixed or random
// handshakes, latency/turnaround points, and reset in fill and in drain.
module tb_stream_frame_buffer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 13;

  logic clk;
  logic reset;

  stream_frame_buffer_if #(.WIDTH(WIDTH)) bus ();

  stream_frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] got_q [$];
  bit               stall_q = 1'b0;
  logic [WIDTH-1:0] held_q  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: records accepted words, checks data holds under stall.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (stall_q && bus.out_valid) check("stall_hold", 32'(bus.out_data), 32'(held_q));
      stall_q = bus.out_valid && !bus.out_ready;
      held_q  = bus.out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // Push one frame and collect DEPTH outputs; optionally offer nxt_word
  // during the drain to show it is not taken before the frame completes.
  task automatic run_frame(input string tag, input logic [WIDTH-1:0] w [DEPTH],
                           input bit rnd_in, input bit rnd_out,
                           input bit nxt_en, input logic [WIDTH-1:0] nxt_word);
    int i = 0;
    int cyc = 0;
    int ph = 0;
    int extra = 0;
    bit hs;
    got_q.delete();
    while (got_q.size() < DEPTH && cyc < 600) begin
      if (i < DEPTH) begin
        bus.in_valid = rnd_in ? 1'($urandom_range(1, 0)) : 1'b1;
        bus.in_data  = w[i];
      end else begin
        bus.in_valid = nxt_en;
        bus.in_data  = nxt_word;
      end
      bus.out_ready = rnd_out ? 1'($urandom_range(1, 0)) : 1'b1;
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (ph == 1) begin
        check({tag, "_lat_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_lat_word0"}, 32'(bus.out_data), 32'(w[0]));
        ph = 2;
      end
      if (hs) begin
        if (i < DEPTH) begin
          i++;
          if (i == DEPTH) begin
            check({tag, "_prime_in_ready"},  32'(bus.in_ready),  32'd0);
            check({tag, "_prime_out_valid"}, 32'(bus.out_valid), 32'd0);
            ph = 1;
          end
        end else begin
          extra++;
        end
      end
    end
    bus.in_valid = 1'b0;
    check({tag, "_out_count"}, 32'(got_q.size()), 32'(DEPTH));
    check({tag, "_early_accept"}, 32'(extra), 32'd0);
    check({tag, "_done_pulse"}, 32'(bus.frame_done), 32'd1);
    check({tag, "_turn_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_turn_out_valid"}, 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      if (k < got_q.size())
        check($sformatf("%s_w%0d", tag, k), 32'(got_q[k]), 32'(w[k]));
    end
    @(posedge clk);
    #1;
    check({tag, "_done_clear"}, 32'(bus.frame_done), 32'd0);
  endtask

  logic [WIDTH-1:0] fa [DEPTH];
  logic [WIDTH-1:0] fb [DEPTH];
  int cyc;

  initial begin
    do_reset();

    // Basic frame 0..12, both sides held ready.
    for (int k = 0; k < DEPTH; k++) fa[k] = WIDTH'(k);
    run_frame("basic", fa, 1'b0, 1'b0, 1'b0, '0);

    // Signed extremes pass through bit-exact.
    for (int k = 0; k < DEPTH; k++) fa[k] = '0;
    fa[0] = 8'h80;
    fa[1] = 8'h7F;
    fa[2] = 8'hFF;
    run_frame("signed", fa, 1'b0, 1'b0, 1'b0, '0);

    // Random stalls on both sides.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < DEPTH; k++) fa[k] = WIDTH'($urandom);
      run_frame($sformatf("rand%0d", r), fa, 1'b1, 1'b1, 1'b0, '0);
    end

    // Back-to-back: B offered during A's drain, then B in its own fill.
    for (int k = 0; k < DEPTH; k++) begin
      fa[k] = WIDTH'(k + 1);
      fb[k] = WIDTH'(k + 101);
    end
    run_frame("b2b_a", fa, 1'b0, 1'b0, 1'b1, fb[0]);
    run_frame("b2b_b", fb, 1'b0, 1'b0, 1'b0, '0);

    // Reset after five fill words, then a clean frame 50..62.
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(k + 90);
      @(posedge clk);
      #1;
    end
    do_reset();
    for (int k = 0; k < DEPTH; k++) fa[k] = WIDTH'(k + 50);
    run_frame("midfill", fa, 1'b0, 1'b0, 1'b0, '0);
    repeat (20) @(posedge clk);
    #1;
    check("midfill_no_leftover", 32'(got_q.size()), 32'(DEPTH));
    check("midfill_idle_valid", 32'(bus.out_valid), 32'd0);

    // Reset after three drain words, then a clean frame 200..212.
    do_reset();
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(k + 7);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("middrain_count", 32'(got_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < got_q.size()) check($sformatf("middrain_w%0d", k), 32'(got_q[k]), 32'(k + 7));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("middrain_valid_drop", 32'(bus.out_valid), 32'd0);
    check("middrain_rdy_in_rst", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("middrain_rdy_after", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < DEPTH; k++) fa[k] = WIDTH'(k + 200);
    run_frame("after_drain_rst", fa, 1'b0, 1'b1, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
